udp_axis_32to8: RTL and testbench

Transmit-side counterpart of the UDP receive path. It takes the 32-bit AXIS stream from the SRIO side (with tfirst/tkeep/tlast) and serialises it, MSB byte first, onto the 8-bit UDP AXIS stream toward the MAC. Per packet it counts emitted bytes and checks the count against the UDP header length field. It reports the actual length and a length-error flag.

---
 rtl/udp_axis_32to8_pkg.sv | 30 +++
 rtl/udp_axis_32to8.sv | 134 +++++++++++++
 tb/tb_udp_axis_32to8.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_axis_32to8_pkg.sv
// Shared UDP framing constants and the last-word tkeep decoder.
package udp_axis_32to8_pkg;

  localparam int UDP_LEN_OFFSET = 4;
  localparam int UDP_HDR_BYTES  = 8;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  typedef struct packed {
    logic       bad;
    logic [2:0] n;
  } keep_cnt_t;

  // Only MSB-aligned contiguous masks are legal; anything else sends a full word and is flagged.
  function automatic keep_cnt_t keep_to_cnt(input logic [3:0] keep);
    keep_cnt_t r;
    case (keep)
      4'b1111: r = '{bad: 1'b0, n: 3'd4};
      4'b1110: r = '{bad: 1'b0, n: 3'd3};
      4'b1100: r = '{bad: 1'b0, n: 3'd2};
      4'b1000: r = '{bad: 1'b0, n: 3'd1};
      default: r = '{bad: 1'b1, n: 3'd4};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/udp_axis_32to8.sv
// 32-bit to 8-bit AXIS serialiser, MSB byte first, with per-packet UDP length check.
// Latency: word accepted on cycle N shows its first byte on N+1; 1 byte/cycle sustained.
// Backpressure: one holding word; tready_out reopens combinationally on the last byte handshake.
module udp_axis_32to8
  import udp_axis_32to8_pkg::*;
#(
  parameter int LEN_OFFSET = UDP_LEN_OFFSET,
  parameter bit CHECK_LEN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] axis_tdata_in,
  input  logic        axis_tvalid_in,
  input  logic        axis_tfirst_in,
  input  logic [3:0]  axis_tkeep_in,
  input  logic        axis_tlast_in,
  output logic        axis_tready_out,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  input  logic        udp_axis_tready_in,
  output logic [15:0] udp_length_out,
  output logic        udp_length_valid_out,
  output logic        len_err_out
);

  localparam logic [15:0] OFF_HI  = 16'(LEN_OFFSET);
  localparam logic [15:0] OFF_LO  = 16'(LEN_OFFSET + 1);
  localparam logic [15:0] MIN_LEN = 16'(LEN_OFFSET + 2);

  state_t      state, state_nxt;
  logic [31:0] hold_dat;
  logic [2:0]  hold_n;
  logic        hold_last;
  logic        hold_bad;
  logic [1:0]  byte_idx;
  keep_cnt_t   kc;

  logic in_hs, out_hs, last_byte, eop, mid_first;
  logic [15:0] byte_cnt, cnt_inc, hdr_len, hdr_nxt;
  logic        pkt_open;

  assign kc        = keep_to_cnt(axis_tkeep_in);
  assign last_byte = ({1'b0, byte_idx} == (hold_n - 3'd1));
  assign out_hs    = udp_axis_tvalid_out & udp_axis_tready_in;
  assign axis_tready_out = reset_n & ((state == ST_IDLE) | (out_hs & last_byte));
  assign in_hs     = axis_tvalid_in & axis_tready_out;

  assign udp_axis_tvalid_out = (state == ST_SHIFT);
  assign udp_axis_tlast_out  = udp_axis_tvalid_out & hold_last & last_byte;

  always_comb begin
    udp_axis_tdata_out = hold_dat[31:24];
    case (byte_idx)
      2'd0: udp_axis_tdata_out = hold_dat[31:24];
      2'd1: udp_axis_tdata_out = hold_dat[23:16];
      2'd2: udp_axis_tdata_out = hold_dat[15:8];
      2'd3: udp_axis_tdata_out = hold_dat[7:0];
      default: udp_axis_tdata_out = hold_dat[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_hs) state_nxt = ST_SHIFT;
      ST_SHIFT: if (out_hs && last_byte) state_nxt = in_hs ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_dat  <= '0;
      hold_n    <= 3'd4;
      hold_last <= 1'b0;
      hold_bad  <= 1'b0;
      byte_idx  <= '0;
    end else if (in_hs) begin
      hold_dat  <= axis_tdata_in;
      hold_last <= axis_tlast_in;
      hold_n    <= axis_tlast_in ? kc.n : 3'd4;
      hold_bad  <= axis_tlast_in & kc.bad;
      byte_idx  <= '0;
    end else if (out_hs && !last_byte) begin
      byte_idx  <= byte_idx + 2'd1;
    end
  end

  // Packet statistics: header length is picked off the output byte stream itself.
  assign cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign eop       = out_hs & udp_axis_tlast_out;
  assign mid_first = in_hs & axis_tfirst_in & pkt_open;

  always_comb begin
    hdr_nxt = hdr_len;
    if (out_hs && byte_cnt == OFF_HI) hdr_nxt[15:8] = udp_axis_tdata_out;
    if (out_hs && byte_cnt == OFF_LO) hdr_nxt[7:0]  = udp_axis_tdata_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt             <= '0;
      hdr_len              <= '0;
      pkt_open             <= 1'b0;
      udp_length_out       <= '0;
      udp_length_valid_out <= 1'b0;
      len_err_out          <= 1'b0;
    end else begin
      udp_length_valid_out <= eop;
      len_err_out <= CHECK_LEN &&
                     ((eop && ((hdr_nxt != cnt_inc) || hold_bad || (cnt_inc < MIN_LEN))) ||
                      mid_first);
      if (eop) udp_length_out <= cnt_inc;
      if (in_hs) pkt_open <= ~axis_tlast_in;
      if (in_hs && axis_tfirst_in) begin
        byte_cnt <= '0;
        hdr_len  <= '0;
      end else if (eop) begin
        byte_cnt <= '0;
        hdr_len  <= '0;
      end else if (out_hs) begin
        byte_cnt <= cnt_inc;
        hdr_len  <= hdr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_udp_axis_32to8.sv
// Scoreboard bench for udp_axis_32to8: expected bytes/lengths/errors are modelled as words are driven.
module tb_udp_axis_32to8;

  localparam int OFF = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tfirst = 1'b0, tlast = 1'b0;
  logic [3:0]  tkeep = 4'hF;
  logic        tready_in = 1'b1;
  logic        tready, tready2;
  logic [7:0]  od, od2;
  logic        ov, ov2, ol, ol2, lv, lv2, le, le2;
  logic [15:0] len, len2;

  always #5 clk = ~clk;

  udp_axis_32to8 #(.LEN_OFFSET(OFF), .CHECK_LEN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .axis_tdata_in(tdata), .axis_tvalid_in(tvalid), .axis_tfirst_in(tfirst),
    .axis_tkeep_in(tkeep), .axis_tlast_in(tlast), .axis_tready_out(tready),
    .udp_axis_tdata_out(od), .udp_axis_tvalid_out(ov), .udp_axis_tlast_out(ol),
    .udp_axis_tready_in(tready_in),
    .udp_length_out(len), .udp_length_valid_out(lv), .len_err_out(le));

  udp_axis_32to8 #(.CHECK_LEN(1'b0)) dut_nc (
    .clk(clk), .reset_n(reset_n),
    .axis_tdata_in(tdata), .axis_tvalid_in(tvalid), .axis_tfirst_in(tfirst),
    .axis_tkeep_in(tkeep), .axis_tlast_in(tlast), .axis_tready_out(tready2),
    .udp_axis_tdata_out(od2), .udp_axis_tvalid_out(ov2), .udp_axis_tlast_out(ol2),
    .udp_axis_tready_in(tready_in),
    .udp_length_out(len2), .udp_length_valid_out(lv2), .len_err_out(le2));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic [8:0]  exp_q[$], obs_q[$];
  int          obs_cyc_q[$];
  logic [15:0] len_q[$], exp_len_q[$];
  int err_cnt, err2_cnt, exp_err, stall_bad, rdy_bad;

  logic [31:0] pw[8];
  logic [3:0]  pk[8];
  logic        pf[8], pl[8];
  int          pn;

  int          m_cnt;
  logic [15:0] m_hdr;
  logic        m_open;

  logic        stall_mode = 1'b0;
  int          stall_ph = 0;
  logic [5:0]  stall_pat = 6'b101001;
  logic [8:0]  prev_out;
  logic        prev_stall = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (stall_mode) begin
      tready_in = stall_pat[stall_ph];
      stall_ph  = (stall_ph + 1) % 6;
    end else begin
      tready_in = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ov && tready_in) begin
        obs_q.push_back({ol, od});
        obs_cyc_q.push_back(cyc);
      end
      if (prev_stall && (!ov || {ol, od} !== prev_out)) stall_bad++;
      if (ov && !tready_in && tready) rdy_bad++;
      prev_stall = ov & ~tready_in;
      prev_out   = {ol, od};
      if (lv) len_q.push_back(len);
      if (le) err_cnt++;
      if (le2) err2_cnt++;
    end
  end

  task automatic clear_sb;
    exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    len_q.delete(); exp_len_q.delete();
    err_cnt = 0; err2_cnt = 0; exp_err = 0; stall_bad = 0; rdy_bad = 0;
  endtask

  task automatic load(input int id);
    for (int i = 0; i < 8; i++) begin pk[i] = 4'hF; pf[i] = 1'b0; pl[i] = 1'b0; pw[i] = '0; end
    case (id)
      1: begin pn = 3; pw[0] = 32'h0001000C; pw[1] = 32'h04050607; pw[2] = 32'h08090A0B; end
      2: begin pn = 3; pw[0] = 32'h1122000A; pw[1] = 32'h33445566; pw[2] = 32'h7788EEFF; pk[2] = 4'b1100; end
      3: begin pn = 2; pw[0] = 32'hAABB0020; pw[1] = 32'h01020304; end
      4: begin pn = 2; pw[0] = 32'h00000008; pw[1] = 32'h11223344; pk[1] = 4'b1010; end
      5: begin pn = 1; pw[0] = 32'hAB000000; pk[0] = 4'b1000; end
      default: begin
        pn = 5; pw[0] = 32'h0000000C; pw[1] = 32'h11111111;
        pw[2] = 32'h0001000C; pw[3] = 32'h04050607; pw[4] = 32'h08090A0B; pf[2] = 1'b1;
      end
    endcase
    pf[0] = 1'b1;
    pl[pn-1] = 1'b1;
  endtask

  // Reference model: predicts the byte stream, reported length and error pulses for one word.
  task automatic model_word(input logic [31:0] w, input logic [3:0] k, input logic f, input logic l);
    int n; logic bad; logic [7:0] b;
    if (f) begin
      if (m_open) exp_err++;
      m_cnt = 0; m_hdr = '0;
    end
    n = 4; bad = 1'b0;
    if (l) begin
      case (k)
        4'b1111: n = 4;
        4'b1110: n = 3;
        4'b1100: n = 2;
        4'b1000: n = 1;
        default: begin n = 4; bad = 1'b1; end
      endcase
    end
    for (int j = 0; j < n; j++) begin
      b = w[31-8*j -: 8];
      if (m_cnt == OFF)     m_hdr[15:8] = b;
      if (m_cnt == OFF + 1) m_hdr[7:0]  = b;
      m_cnt++;
      exp_q.push_back({(l && j == n - 1), b});
    end
    if (l) begin
      exp_len_q.push_back(16'(m_cnt));
      if (m_cnt < OFF + 2 || m_hdr != 16'(m_cnt) || bad) exp_err++;
    end
    m_open = ~l;
  endtask

  task automatic send_word(input int i);
    int t;
    tdata = pw[i]; tkeep = pk[i]; tfirst = pf[i]; tlast = pl[i]; tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (tready) break;
      t++;
      if (t > 200) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout: word %0d tready_out=%b, required 1 within 200 cycles", i, tready);
        break;
      end
    end
    @(posedge clk); #1;
    tvalid = 1'b0; tfirst = 1'b0; tlast = 1'b0;
  endtask

  task automatic run_pkt;
    int t;
    for (int i = 0; i < pn; i++) begin
      model_word(pw[i], pk[i], pf[i], pl[i]);
      send_word(i);
    end
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 300) begin @(posedge clk); t++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    n_chk++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b, required 0", tready); end
    n_chk++; if ({ov, ol, od} !== 10'h0) begin n_fail++; $display("FAIL reset_out: got %h, required 000", {ov, ol, od}); end
    n_chk++; if ({lv, le, len} !== 18'h0) begin n_fail++; $display("FAIL reset_stats: got %h, required 00000", {lv, le, len}); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL idle_tready: got %b, required 1", tready); end
    m_open = 1'b0;
  endtask

  task automatic test_basic;
    logic [8:0] g, e; int c0, c1;
    clear_sb(); load(1); run_pkt();
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size()); end
    c0 = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : 0;
    c1 = (obs_cyc_q.size() > 0) ? obs_cyc_q[obs_cyc_q.size()-1] : 0;
    n_chk++; if (c1 - c0 !== 11) begin n_fail++; $display("FAIL basic_span: got %0d cycles, required 11", c1 - c0); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL basic_byte: got {last,data}=%h, required %h", g, e); end
    end
    n_chk++; if (len_q.size() !== 1) begin n_fail++; $display("FAIL basic_lenvld: got %0d pulses, required 1", len_q.size()); end
    n_chk++; if (len_q.size() > 0 && len_q[0] !== exp_len_q[0]) begin n_fail++; $display("FAIL basic_len: got %0d, required %0d", len_q[0], exp_len_q[0]); end
    n_chk++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL basic_err: got %0d pulses, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_partial_keep;
    logic [8:0] g, e;
    clear_sb(); load(2); run_pkt();
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL keep_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL keep_byte: got {last,data}=%h, required %h", g, e); end
    end
    n_chk++; if (len_q.size() !== 1 || len_q[0] !== exp_len_q[0]) begin n_fail++; $display("FAIL keep_len: got %0d pulses first=%0d, required 1 pulse of %0d", len_q.size(), (len_q.size() > 0) ? len_q[0] : 0, exp_len_q[0]); end
    n_chk++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL keep_err: got %0d pulses, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_len_errors;
    logic [8:0] g, e; int nc_errs;
    nc_errs = 0;
    for (int id = 3; id <= 5; id++) begin
      clear_sb(); load(id); run_pkt();
      nc_errs += err2_cnt;
      n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL err%0d_count: got %0d bytes, required %0d", id, obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        g = obs_q.pop_front(); e = exp_q.pop_front();
        n_chk++; if (g !== e) begin n_fail++; $display("FAIL err%0d_byte: got {last,data}=%h, required %h", id, g, e); end
      end
      n_chk++; if (len_q.size() !== 1 || len_q[0] !== exp_len_q[0]) begin n_fail++; $display("FAIL err%0d_len: got %0d pulses first=%0d, required 1 pulse of %0d", id, len_q.size(), (len_q.size() > 0) ? len_q[0] : 0, exp_len_q[0]); end
      n_chk++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL err%0d_err: got %0d pulses, required %0d", id, err_cnt, exp_err); end
    end
    n_chk++; if (nc_errs !== 0) begin n_fail++; $display("FAIL nocheck_err: got %0d pulses with CHECK_LEN=0, required 0", nc_errs); end
  endtask

  task automatic test_stall;
    logic [8:0] g, e;
    clear_sb(); load(1);
    stall_mode = 1'b1;
    run_pkt();
    stall_mode = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL stall_byte: got {last,data}=%h, required %h", g, e); end
    end
    n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable stall cycles, required 0", stall_bad); end
    n_chk++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL stall_tready: got %0d cycles tready_out high while stalled, required 0", rdy_bad); end
    n_chk++; if (len_q.size() !== 1 || len_q[0] !== exp_len_q[0]) begin n_fail++; $display("FAIL stall_len: got %0d pulses first=%0d, required 1 pulse of %0d", len_q.size(), (len_q.size() > 0) ? len_q[0] : 0, exp_len_q[0]); end
    n_chk++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL stall_err: got %0d pulses, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_mid_first;
    logic [8:0] g, e;
    clear_sb(); load(6); run_pkt();
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midfirst_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL midfirst_byte: got {last,data}=%h, required %h", g, e); end
    end
    n_chk++; if (len_q.size() !== exp_len_q.size()) begin n_fail++; $display("FAIL midfirst_lenvld: got %0d pulses, required %0d", len_q.size(), exp_len_q.size()); end
    n_chk++; if (len_q.size() > 0 && len_q[0] !== exp_len_q[0]) begin n_fail++; $display("FAIL midfirst_len: got %0d, required %0d", len_q[0], exp_len_q[0]); end
    n_chk++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL midfirst_err: got %0d pulses, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_reset_midword;
    logic [8:0] g, e;
    clear_sb(); load(1);
    tdata = pw[0]; tkeep = pk[0]; tfirst = 1'b1; tlast = 1'b0; tvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    tvalid = 1'b0; tfirst = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_chk++; if ({ov, ol, od} !== 10'h0) begin n_fail++; $display("FAIL midrst_out: got %h, required 000", {ov, ol, od}); end
    n_chk++; if ({tready, lv, le} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctl: got %b, required 000", {tready, lv, le}); end
    n_chk++; if (len !== 16'h0) begin n_fail++; $display("FAIL midrst_len: got %h, required 0000", len); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_open = 1'b0;
    clear_sb();
    @(posedge clk); #1;
    run_pkt();
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL postrst_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL postrst_byte: got {last,data}=%h, required %h", g, e); end
    end
    n_chk++; if (len_q.size() !== 1 || len_q[0] !== exp_len_q[0]) begin n_fail++; $display("FAIL postrst_len: got %0d pulses first=%0d, required 1 pulse of %0d", len_q.size(), (len_q.size() > 0) ? len_q[0] : 0, exp_len_q[0]); end
    n_chk++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL postrst_err: got %0d pulses, required %0d", err_cnt, exp_err); end
  endtask

  initial begin
    m_open = 1'b0; m_cnt = 0; m_hdr = '0;
    test_reset();
    test_basic();
    test_partial_keep();
    test_len_errors();
    test_stall();
    test_mid_first();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
